// File: rtl/sync_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first.
// start is accepted in IDLE or DONE; done pulses for one cycle with q/r/div_by_zero valid.
module sync_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] dvd, dvd_nx;
    logic [WIDTH-1:0] dsr, dsr_nx;
    logic [WIDTH-1:0] rem, rem_nx;
    logic [WIDTH-1:0] quo, quo_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] q_nx, r_nx;
    logic             dbz_nx;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             fits;

    // rem < 2^(WIDTH-1) before every shift (it is bounded by the dividend prefix),
    // so rem_sh fits in WIDTH bits and bit WIDTH of the difference is a clean borrow.
    assign rem_sh = {rem, dvd[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dsr};
    assign fits   = ~diff[WIDTH];

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_nx = state;
        dvd_nx   = dvd;
        dsr_nx   = dsr;
        rem_nx   = rem;
        quo_nx   = quo;
        cnt_nx   = cnt;
        q_nx     = q;
        r_nx     = r;
        dbz_nx   = div_by_zero;

        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (start) begin
                    if (b == '0) begin
                        state_nx = DONE;
                        q_nx     = '1;
                        r_nx     = a;
                        dbz_nx   = 1'b1;
                    end else begin
                        state_nx = RUN;
                        dvd_nx   = a;
                        dsr_nx   = b;
                        rem_nx   = '0;
                        quo_nx   = '0;
                        cnt_nx   = '0;
                    end
                end
            end

            RUN: begin
                dvd_nx = {dvd[WIDTH-2:0], 1'b0};
                rem_nx = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                quo_nx = {quo[WIDTH-2:0], fits};
                cnt_nx = cnt + 1'b1;
                if (cnt == CW'(WIDTH-1)) begin
                    state_nx = DONE;
                    q_nx     = quo_nx;
                    r_nx     = rem_nx;
                    dbz_nx   = 1'b0;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nx;
            dvd         <= dvd_nx;
            dsr         <= dsr_nx;
            rem         <= rem_nx;
            quo         <= quo_nx;
            cnt         <= cnt_nx;
            q           <= q_nx;
            r           <= r_nx;
            div_by_zero <= dbz_nx;
        end
    end

endmodule

// File: tb/tb_sync_divider.sv
// Scoreboard bench for sync_divider: expected {div_by_zero, q, r} and done cycle are
// queued at issue time; a negedge monitor pops and compares on every done pulse.
module tb_sync_divider;

    localparam int W  = 8;
    localparam int EW = 2 * W + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] q, r;

    always #5 clk = ~clk;

    sync_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain integer division; b == 0 gives all-ones quotient and r = a.
    function automatic logic [EW-1:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] qq, rr;
        if (y == 0) return {1'b1, {W{1'b1}}, x};
        qq = x / y;
        rr = x % y;
        return {1'b0, qq, rr};
    endfunction

    // Called at a negedge; the following posedge accepts.
    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, output int dcyc);
        start = 1'b1;
        a     = x;
        b     = y;
        dcyc  = cyc + 1 + ((y == 0) ? 0 : W);
        exp_q.push_back(ref_div(x, y));
        exp_cyc_q.push_back(dcyc);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
        int d;
        accept(x, y, d);
        @(negedge clk);
        if (!hold) start = 1'b0;
        wait_cyc(d);
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        int            ec;
        if (rst_n === 1'b1) begin
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("q", q, e[2*W-1:W]);
                    check("r", r, e[W-1:0]);
                    check("div_by_zero", div_by_zero, e[2*W]);
                    check("done_cycle", cyc, ec);
                end
            end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_done: got done=0 expected done at cycle %0d (cycle %0d)",
                         exp_cyc_q[0], cyc);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        logic [W-1:0] x, y;
        bit hold;
        int gap;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 7 / 2 with busy tracked over the run and outputs held afterwards
        accept(8'd7, 8'd2, d);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            check("busy_run", busy, 1);
            @(negedge clk);
        end
        check("busy_at_done", busy, 0);
        @(negedge clk);
        check("done_cleared", done, 0);
        check("q_held_idle", q, 3);
        check("r_held_idle", r, 1);

        op(8'd255, 8'd1, 1'b0);
        op(8'd3, 8'd7, 1'b0);
        op(8'd128, 8'd255, 1'b0);

        // divide by zero from IDLE, then a normal op clears the flag
        @(negedge clk);
        accept(8'd5, 8'd0, d);
        @(negedge clk);
        start = 1'b0;
        check("busy_dbz", busy, 0);
        op(8'd9, 8'd3, 1'b0);

        // start during RUN is ignored
        @(negedge clk);
        accept(8'd200, 8'd7, d);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        a     = 8'd1;
        b     = 8'd1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(d);

        // start held high: back-to-back accept from DONE
        @(negedge clk);
        op(8'd100, 8'd10, 1'b1);
        op(8'd17, 8'd5, 1'b0);

        // asynchronous reset mid-run aborts without a done pulse
        @(negedge clk);
        accept(8'd200, 8'd7, d);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_q", q, 0);
        check("arst_r", r, 0);
        check("arst_dbz", div_by_zero, 0);
        exp_q.delete();
        exp_cyc_q.delete();
        #1 rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        op(8'd250, 8'd9, 1'b0);

        // randomized operations, occasional zero divisor and back-to-back issue
        repeat (40) begin
            x    = W'($urandom_range(0, 255));
            y    = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
            hold = 1'($urandom_range(0, 1));
            gap  = $urandom_range(0, 2);
            op(x, y, hold);
            if (gap > 0) begin
                start = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end

        start = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_divider.md
Name: sync_divider

Overview:
Iterative unsigned restoring divider, the inverse arithmetic companion to the 8-bit synchronous adder. It computes quotient and remainder of A / B, producing one quotient bit per clock. A start/busy/done handshake lets a controller or bench issue operations and collect registered results. The block sits beside the adder in the arithmetic datapath.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (WIDTH >= 2).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled on rising clk edge, accepted only in IDLE or DONE.
a  input  WIDTH  dividend; captured on accepted start.
b  input  WIDTH  divisor; captured on accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle completion pulse; q, r and div_by_zero are valid while high.
q  output  WIDTH  quotient.
r  output  WIDTH  remainder.
div_by_zero  output  1  result flag: last accepted operation had b == 0.

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, busy=0, done=0, q=0, r=0, div_by_zero=0, internal registers=0. Release takes effect at the next rising edge.
- States: IDLE, RUN, DONE.
- IDLE: start=0 -> stay. start=1 and b!=0 -> RUN, latch a and b, partial remainder=0, step count=0, busy=1. start=1 and b==0 -> DONE.
- Divide-by-zero on accept: q=all ones (2^WIDTH-1), r=a, div_by_zero=1, done=1 on the cycle after the accepting edge. Latency is 1 cycle.
- RUN, one step per edge, MSB first:
  - rem' = {rem[WIDTH-2:0], dividend MSB}; dividend shifts left 1.
  - If rem' >= divisor, rem = rem' - divisor and the quotient bit is 1; else rem = rem' and the bit is 0.
  - The comparison uses a WIDTH+1-bit difference.
- After exactly WIDTH steps (edges E1..E_WIDTH following the accepting edge E0): state=DONE, busy=0, q and r updated, div_by_zero=0, done=1. Latency is WIDTH cycles from the accepting edge to done visible.
- DONE lasts exactly one cycle; done=1 only in this state.
  - start=1 -> accepted as in IDLE (back-to-back operation, no idle bubble).
  - start=0 -> IDLE.
- start during RUN is ignored; the operand change has no effect on the in-flight result.
- q, r and div_by_zero hold their last values in IDLE and RUN. They change only on entry to DONE or on reset.
- a and b only need to be stable at the accepting edge.
- Invariant at done with b != 0: q*b + r == a and r < b.
- Reset mid-RUN aborts the operation: no done pulse, outputs return to reset values.

Test Plan:
- a=7, b=2, start 1 cycle -> busy for 8 cycles; then done=1 for 1 cycle with q=3, r=1, div_by_zero=0.
- a=255, b=1 -> q=255, r=0. a=3, b=7 -> q=0, r=3. a=128, b=255 -> q=0, r=128 (each done 8 cycles after accept).
- a=5, b=0 -> done on the next cycle with q=255, r=5, div_by_zero=1, and busy never high. Then a=9, b=3 -> q=3, r=0, div_by_zero cleared.
- Accept a=200, b=7; 3 cycles later drive start=1 with a=1, b=1 -> ignored; result q=28, r=4 at 8 cycles after the first accept.
- start held high with a=100, b=10 then a=17, b=5 -> results q=10 r=0, then q=3 r=2, with done pulses exactly 9 cycles apart.
- Drop rst_n low for a partial cycle mid-RUN (step 4) -> busy, done, q, r and div_by_zero go to 0 immediately and asynchronously, with no done pulse. A new start after release completes normally.
